servo_ramp_ctrl: RTL

- Avalon-MM-controlled servo pulse sequencer for the forklift's servo outputs.
- Generates a fixed-period PWM frame and slews the pulse width toward a software-set target by a programmable step per frame, so the motor never sees a jump.
- Pulse width changes only at frame boundaries, so no frame ever carries a truncated or glitched pulse.
- Sits between the HPS/Nios Avalon bus and a servo conduit; replaces hard-wired fixed-duty generation.

---
 rtl/servo_ramp_ctrl_if.sv | 23 ++
 rtl/servo_ramp_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/servo_ramp_ctrl_if.sv
// Avalon-MM slave port plus servo conduit for servo_ramp_ctrl.
// Handshake: a write is accepted on every clock where avs_write=1 (no wait states);
// avs_read=1 returns data on avs_readdata one clock later, held until the next read.
interface servo_ramp_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        pwm_out;
    logic        busy;
    logic        frame_tick;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, pwm_out, busy, frame_tick
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, pwm_out, busy, frame_tick
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Fixed-period servo PWM whose pulse width slews toward a target by a
// programmable step, changing only at frame boundaries.
module servo_ramp_ctrl #(
    parameter int unsigned FRAME_CLKS = 2000000,
    parameter int unsigned PULSE_MIN  = 50000,
    parameter int unsigned PULSE_MAX  = 250000,
    parameter int unsigned PULSE_INIT = 150000,
    parameter int unsigned STEP_INIT  = 1000
) (
    input  logic             clock_clk,
    input  logic             reset_reset,
    servo_ramp_ctrl_if.slave bus
);
    localparam int CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CLKS - 1);

    logic          r_enable;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_cur;
    logic [31:0]   r_tgt;
    logic [31:0]   r_step;
    logic          r_pwm;
    logic          r_tick;
    logic [31:0]   r_rdata;

    logic          w_wr_ctrl;
    logic          w_en_next;
    logic          w_boundary;
    logic          w_busy;
    logic [31:0]   w_tgt_clamped;
    logic [32:0]   w_up_diff;
    logic [32:0]   w_dn_diff;
    logic [31:0]   w_ramp;

    assign w_wr_ctrl  = bus.avs_write && (bus.avs_address == 2'd0);
    // A disabling write kills the pulse on the very next cycle, not one later.
    assign w_en_next  = w_wr_ctrl ? bus.avs_writedata[0] : r_enable;
    assign w_boundary = r_enable && (r_cnt == CNT_LAST);
    assign w_busy     = (r_cur != r_tgt);

    always_comb begin
        w_tgt_clamped = bus.avs_writedata;
        if (bus.avs_writedata < PULSE_MIN)
            w_tgt_clamped = PULSE_MIN;
        else if (bus.avs_writedata > PULSE_MAX)
            w_tgt_clamped = PULSE_MAX;
    end

    // Differences are taken 33 bits wide so a huge step can never wrap past the target.
    always_comb begin
        w_up_diff = {1'b0, r_tgt} - {1'b0, r_cur};
        w_dn_diff = {1'b0, r_cur} - {1'b0, r_tgt};
        w_ramp    = r_cur;
        if (r_step == 32'd0)
            w_ramp = r_tgt;
        else if (r_cur < r_tgt)
            w_ramp = (w_up_diff <= {1'b0, r_step}) ? r_tgt : r_cur + r_step;
        else if (r_cur > r_tgt)
            w_ramp = (w_dn_diff <= {1'b0, r_step}) ? r_tgt : r_cur - r_step;
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_enable <= 1'b0;
            r_cnt    <= '0;
            r_cur    <= PULSE_INIT;
            r_tgt    <= PULSE_INIT;
            r_step   <= STEP_INIT;
            r_pwm    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_enable <= w_en_next;
            if (!w_en_next)
                r_cnt <= '0;
            else if (r_enable)
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
            if (w_boundary)
                r_cur <= w_ramp;
            if (bus.avs_write && bus.avs_address == 2'd1)
                r_tgt <= w_tgt_clamped;
            if (bus.avs_write && bus.avs_address == 2'd2)
                r_step <= bus.avs_writedata;
            r_pwm  <= w_en_next && r_enable && (32'(r_cnt) < r_cur);
            r_tick <= w_en_next && w_boundary;
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_rdata <= '0;
        end else if (bus.avs_read) begin
            case (bus.avs_address)
                2'd0:    r_rdata <= {30'd0, w_busy, r_enable};
                2'd1:    r_rdata <= r_tgt;
                2'd2:    r_rdata <= r_step;
                default: r_rdata <= r_cur;
            endcase
        end
    end

    assign bus.avs_readdata = r_rdata;
    assign bus.pwm_out      = r_pwm;
    assign bus.busy         = w_busy;
    assign bus.frame_tick   = r_tick;
endmodule
